trolley_motor_pwm: RTL

Parametrised multi-channel DC motor driver, an Avalon-MM slave in the trolley Qsys system that replaces raw per-motor PIO bits. Each channel produces a 3-bit H-bridge drive (PWM, IN1, IN2) from a programmed target duty and direction. Speed changes are slew-limited, and direction reversals pass through zero speed. A proximity-sensor input latches an emergency brake on all channels.

---
 rtl/trolley_motor_pwm.sv | 106 ++++++++++
 1 files changed

// File: rtl/trolley_motor_pwm.sv
// trolley_motor_pwm: Avalon-MM multi-channel H-bridge PWM driver with slew-limited ramps and latched e-stop
module trolley_motor_pwm #(
  parameter int CHANNELS  = 2,
  parameter int PWM_W     = 8,
  parameter int PRESCALE  = 50,
  parameter int RAMP_STEP = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              avs_address,
  input  logic                    avs_write,
  input  logic                    avs_read,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  input  logic                    stop_in,
  output logic [3*CHANNELS-1:0]   motor_out
);
  localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PWM_W-1:0] CNT_TOP = PWM_W'((1 << PWM_W) - 2);
  localparam logic [PWM_W:0] STEP = (PWM_W + 1)'(RAMP_STEP);
  logic [PS_W-1:0] pre;
  logic [PWM_W-1:0] pwm_cnt;
  logic tick, period_end, s1, stop_sync, estop, clr_wr, unused_wd;
  logic [CHANNELS-1:0][PWM_W-1:0] tgt, cur;
  logic [CHANNELS-1:0] dir, brk, adir;
  logic [3*CHANNELS-1:0] motor_nxt;
  logic [31:0] rd_val;

  // One slew step; when reversing, the step heads toward zero regardless of target
  function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] t, input logic [PWM_W-1:0] c, input logic rev);
    logic [PWM_W:0] d, s;
    d = rev ? {1'b0, c} : t > c ? {1'b0, t} - {1'b0, c} : {1'b0, c} - {1'b0, t};
    s = d > STEP ? STEP : d;
    return (t > c && !rev) ? PWM_W'({1'b0, c} + s) : PWM_W'({1'b0, c} - s);
  endfunction

  assign tick       = pre == PS_W'(PRESCALE - 1);
  assign period_end = tick && pwm_cnt == CNT_TOP;
  assign clr_wr     = avs_write && avs_address == 4'hf && avs_writedata[0];
  assign unused_wd  = ^avs_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      pwm_cnt   <= '0;
      s1        <= 1'b0;
      stop_sync <= 1'b0;
      estop     <= 1'b0;
    end else begin
      pre       <= tick ? '0 : pre + 1'b1;
      pwm_cnt   <= tick ? (period_end ? '0 : pwm_cnt + 1'b1) : pwm_cnt;
      s1        <= stop_in;
      stop_sync <= s1;
      estop     <= stop_sync | (estop & ~clr_wr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt  <= '0;
      cur  <= '0;
      dir  <= '0;
      brk  <= '0;
      adir <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (stop_sync) begin
          tgt[c] <= '0;
          brk[c] <= 1'b0;
        end else if (avs_write && avs_address == 4'(c) && !estop) begin
          tgt[c] <= avs_writedata[PWM_W-1:0];
          dir[c] <= avs_writedata[16];
          brk[c] <= avs_writedata[17];
        end
        if (brk[c] || estop) cur[c] <= '0;
        else if (period_end && dir[c] != adir[c] && cur[c] == '0) adir[c] <= dir[c];
        else if (period_end) cur[c] <= ramp(tgt[c], cur[c], dir[c] != adir[c]);
      end
    end
  end

  always_comb begin
    motor_nxt = '0;
    rd_val    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      motor_nxt[3*c +: 3] = (brk[c] || estop) ? 3'b110 :
                            cur[c] != '0 ? {adir[c], ~adir[c], pwm_cnt < cur[c]} : 3'b000;
      if (avs_address == 4'(c)) begin
        rd_val[PWM_W-1:0]  = tgt[c];
        rd_val[18:16]      = {adir[c], brk[c], dir[c]};
        rd_val[24 +: PWM_W] = cur[c];
      end
    end
    if (avs_address == 4'hf) rd_val[2:0] = {cur == '0, stop_sync, estop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      motor_out    <= '0;
      avs_readdata <= '0;
    end else begin
      motor_out    <= motor_nxt;
      avs_readdata <= avs_read ? rd_val : '0;
    end
  end
endmodule
